// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 16x oversampled start/data/stop recovery with majority vote.
// Optional parity bit checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_deserializer #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 uart_clk,
    input  logic                 PRESETn,
    input  logic                 rx_en,
    input  logic                 baud_tick_x16,
    input  logic                 rx,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = ST_PARITY;
`else
    localparam state_t AFTER_DATA = ST_STOP;
`endif
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_of(input logic [DATA_BITS-1:0] word, input logic pbit);
        return ^{word, pbit};
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;
    logic                   bit_s;

    state_t                 state_r, state_nxt_s;
    logic [3:0]             sub_cnt_r, sub_nxt_s;
    logic [2:0]             bit_idx_r, idx_nxt_s;
    logic [DATA_BITS-1:0]   shift_r, shift_nxt_s;
    logic                   s7_r, s7_nxt_s;
    logic                   s8_r, s8_nxt_s;
    logic                   any_one_r, one_nxt_s;
    logic                   par_pend_r, ppend_nxt_s;
    logic [DATA_BITS-1:0]   data_out_r, dout_nxt_s;
    logic                   data_valid_r, dv_nxt_s;
    logic                   frame_err_r, ferr_nxt_s;
    logic                   parity_err_r, perr_nxt_s;
    logic                   break_det_r, brk_nxt_s;
    logic                   busy_r;

`ifndef UART_RX_PARITY_EN
    logic unused_parity_s;
    assign unused_parity_s = parity_odd;
`endif

    // Input synchronizer; resets to the idle-high line level
    always_ff @(posedge uart_clk or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s  = sync_r[SYNC_STAGES-1];
    assign bit_s = majority3(s7_r, s8_r, rx_s);

    // Next-state and datapath decode
    always_comb begin
        state_nxt_s = state_r;
        sub_nxt_s   = sub_cnt_r;
        idx_nxt_s   = bit_idx_r;
        shift_nxt_s = shift_r;
        s7_nxt_s    = s7_r;
        s8_nxt_s    = s8_r;
        one_nxt_s   = any_one_r;
        ppend_nxt_s = par_pend_r;
        dout_nxt_s  = data_out_r;
        dv_nxt_s    = 1'b0;
        ferr_nxt_s  = frame_err_r;
        perr_nxt_s  = parity_err_r;
        brk_nxt_s   = break_det_r;

        if (!rx_en) begin
            state_nxt_s = ST_IDLE;
            sub_nxt_s   = 4'd0;
            shift_nxt_s = '0;
            brk_nxt_s   = 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (baud_tick_x16 && !rx_s) begin
                state_nxt_s = ST_START;
                sub_nxt_s   = 4'd1;
                one_nxt_s   = 1'b0;
                ppend_nxt_s = 1'b0;
            end else begin
                sub_nxt_s   = 4'd0;
            end
        end else if (state_r == ST_BREAK) begin
            // BREAK exit does not wait for a tick
            if (rx_s) begin
                state_nxt_s = ST_IDLE;
                brk_nxt_s   = 1'b0;
            end else begin
                brk_nxt_s   = 1'b1;
            end
        end else if (baud_tick_x16) begin
            sub_nxt_s = sub_cnt_r + 4'd1;
            case (sub_cnt_r)
                4'd7:    s7_nxt_s = rx_s;
                4'd8:    s8_nxt_s = rx_s;
                default: s7_nxt_s = s7_r;
            endcase

            case (state_r)
                ST_START: begin
                    if (sub_cnt_r == 4'd9 && bit_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (sub_cnt_r == 4'd15) begin
                        state_nxt_s = ST_DATA;
                        idx_nxt_s   = 3'd0;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (sub_cnt_r == 4'd9) begin
                        shift_nxt_s = {bit_s, shift_r[DATA_BITS-1:1]};
                        one_nxt_s   = any_one_r | bit_s;
                    end else if (sub_cnt_r == 4'd15) begin
                        idx_nxt_s = bit_idx_r + 3'd1;
                        if (bit_idx_r == LAST_IDX) begin
                            state_nxt_s = AFTER_DATA;
                        end else begin
                            state_nxt_s = ST_DATA;
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sub_cnt_r == 4'd9) begin
                        one_nxt_s   = any_one_r | bit_s;
                        ppend_nxt_s = (parity_of(shift_r, bit_s) != parity_odd);
                    end else if (sub_cnt_r == 4'd15) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_PARITY;
                    end
                end
`endif
                ST_STOP: begin
                    // Leave at mid-stop so the next start edge is seen early
                    if (sub_cnt_r == 4'd9) begin
                        if (bit_s || any_one_r) begin
                            state_nxt_s = ST_IDLE;
                            dv_nxt_s    = 1'b1;
                            dout_nxt_s  = shift_r;
                            ferr_nxt_s  = ~bit_s;
                            perr_nxt_s  = par_pend_r;
                        end else begin
                            state_nxt_s = ST_BREAK;
                            brk_nxt_s   = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers
    always_ff @(posedge uart_clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r      <= ST_IDLE;
            sub_cnt_r    <= 4'd0;
            bit_idx_r    <= 3'd0;
            shift_r      <= '0;
            s7_r         <= 1'b1;
            s8_r         <= 1'b1;
            any_one_r    <= 1'b0;
            par_pend_r   <= 1'b0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            break_det_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            sub_cnt_r    <= sub_nxt_s;
            bit_idx_r    <= idx_nxt_s;
            shift_r      <= shift_nxt_s;
            s7_r         <= s7_nxt_s;
            s8_r         <= s8_nxt_s;
            any_one_r    <= one_nxt_s;
            par_pend_r   <= ppend_nxt_s;
            data_out_r   <= dout_nxt_s;
            data_valid_r <= dv_nxt_s;
            frame_err_r  <= ferr_nxt_s;
            parity_err_r <= perr_nxt_s;
            break_det_r  <= brk_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign break_det  = break_det_r;
    assign busy       = busy_r;

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side serial-to-parallel stage of the APB UART. It runs in the uart_clk domain and oversamples the RX pin using a 16x baud tick. It recovers start/data/stop framing with a majority vote and hands each received byte to the RX async FIFO as a single-cycle write strobe. It also flags framing errors and line breaks; these feed the RX status register.

## Interface
- DATA_BITS, 8, data bits per frame, LSB first (5..8)
- SYNC_STAGES, 2, flops in the RX input synchronizer (>=2)
- uart_clk  input  1  receive clock; all logic on posedge
- PRESETn  input  1  reset, asynchronous, active-low
- rx_en  input  1  receiver enable (control register RX_EN, already synced)
- baud_tick_x16  input  1  one-uart_clk-cycle enable pulse at 16x baud rate
- rx  input  1  raw serial line, idle high, asynchronous
- parity_odd  input  1  1 = odd parity, 0 = even (used only with UART_RX_PARITY_EN)
- data_out  output  DATA_BITS  last received data word
- data_valid  output  1  one-cycle pulse; drives rx_fifo wr_en
- frame_err  output  1  stop bit sampled 0 for the word in data_out
- parity_err  output  1  parity mismatch for the word in data_out
- break_det  output  1  line break in progress
- busy  output  1  FSM not in IDLE

## Operation
- Synchronizer:
  - rx passes through SYNC_STAGES flops, each reset to 1; the output is rx_s.
  - All sampling uses rx_s.
- Sampling:
  - A 4-bit sub-counter increments on each baud_tick_x16 and wraps 15->0.
  - The bit value is the majority of rx_s at sub-counts 7, 8 and 9; it is decided at sub-count 9.
  - The bit period ends when the sub-counter wraps.
- IDLE:
  - On a tick with rx_en=1 and rx_s=0, go to START with sub-counter=1.
  - busy=0 in this state.
- START:
  - At sub-count 9, majority=1 means a false start (glitch): return to IDLE.
  - Otherwise, at the wrap go to DATA with bit index=0.
- DATA:
  - At sub-count 9, shift the decided bit into the MSB of the shift register (LSB-first reception).
  - At the wrap, increment the index; after DATA_BITS bits go to PARITY (macro) or STOP.
- PARITY (macro only):
  - At sub-count 9, compute the XOR of the data bits and the sampled bit.
  - The expected result is 1 for odd parity and 0 for even; a mismatch is latched as a pending parity error.
  - At the wrap, go to STOP.
- STOP: decided at sub-count 9, then the FSM goes to IDLE without waiting for the wrap (resync margin).
  - Stop=1: data_valid pulse, data_out loaded, frame_err=0.
  - Stop=0 and the start bit, all data bits and the parity bit (if present) were 0: break_det=1, no data_valid, go to BREAK.
  - Stop=0 otherwise: data_valid pulse with frame_err=1; the data is still delivered.
- BREAK:
  - Stay until rx_s=1 (no tick required), then clear break_det and go to IDLE.
- frame_err and parity_err are updated only on data_valid and hold until the next data_valid.
- rx_en=0 in any state:
  - The FSM goes to IDLE on the next cycle and the shift register is discarded.
  - No data_valid is produced and break_det clears.
- With no baud_tick_x16 the FSM freezes, except for the rx_en abort and the BREAK exit.

## Timing
- Reset values:
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, break_det=0, busy=0.
  - FSM=IDLE, synchronizer=all 1.
- Input latency:
  - rx edge to rx_s takes SYNC_STAGES uart_clk cycles.
- data_valid:
  - Asserts in the cycle after the tick at sub-count 9 of the stop bit.
  - data_out, frame_err and parity_err are valid in that same cycle.
  - It is high for exactly 1 uart_clk cycle per frame and is never asserted two cycles in a row.
- busy:
  - Rises in the cycle after the start-detect tick.
  - Falls together with the data_valid pulse, or in the cycle after a false start or rx_en abort.
- Back-to-back frames:
  - A new start bit is accepted from the first tick after returning to IDLE, i.e. half a bit into the stop bit.
- Reset asserted mid-frame:
  - All state and outputs return to reset values immediately (asynchronous).
  - No partial word is emitted after reset release.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state exists and one parity bit is expected between the data and stop bits.
  - parity_err reports the mismatch.
- Not defined:
  - No PARITY state; the frame is start + DATA_BITS + stop.
  - parity_err is tied to 0 and parity_odd is ignored.

## Test plan
- Clean frame: tick every 4 cycles, rx_en=1, send 0xA5 with stop=1 -> one data_valid pulse, data_out=0xA5, frame_err=0, busy low afterwards.
- Glitch: rx low for 3 ticks, then high -> no data_valid; busy returns to 0 after sub-count 9 of START.
- Framing error: send 0x3C with stop=0 -> data_valid pulse, data_out=0x3C, frame_err=1; the next clean 0x01 clears frame_err.
- Break: rx low for 12 bit times -> break_det=1 with no data_valid; break_det clears SYNC_STAGES+1 cycles after rx returns high.
- Back-to-back and abort:
  - 0x55 then 0xAA with a single stop bit -> two pulses with correct values.
  - rx_en dropped in DATA bit 4 -> no pulse, busy=0 next cycle.
- UART_RX_PARITY_EN, parity_odd=1:
  - Send 0x07 with parity bit 1 -> parity_err=1.
  - Send 0x07 with parity bit 0 -> parity_err=0.
